// File: rtl/vga_timing_gen.sv
// Raster timing generator (800x600@72 default): x/y position, syncs, blank and SOF/EOF markers.
// All outputs registered and aligned to x/y, one clk after the advancing pix_ce edge; free-running, no backpressure.
module vga_timing_gen #(
  parameter int HACTIVE = 800,
  parameter int HFP     = 56,
  parameter int HSYNC   = 120,
  parameter int HBP     = 64,
  parameter int VACTIVE = 600,
  parameter int VFP     = 37,
  parameter int VSYNC   = 6,
  parameter int VBP     = 23,
  parameter bit HS_POL  = 1'b1,
  parameter bit VS_POL  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_ce,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        hsync,
  output logic        vsync,
  output logic        blank,
  output logic        SOF,
  output logic        EOF,
  output logic [7:0]  frame_cnt
);

  localparam int HTOTAL = HACTIVE + HFP + HSYNC + HBP;
  localparam int VTOTAL = VACTIVE + VFP + VSYNC + VBP;

  localparam logic [10:0] X_LAST = 11'(HTOTAL - 1);
  localparam logic [10:0] Y_LAST = 11'(VTOTAL - 1);
  localparam logic [10:0] X_ACT  = 11'(HACTIVE);
  localparam logic [10:0] Y_ACT  = 11'(VACTIVE);
  localparam logic [10:0] Y_EOF  = 11'(VACTIVE - 1);
  localparam logic [10:0] HS_ON  = 11'(HACTIVE + HFP);
  localparam logic [10:0] HS_OFF = 11'(HACTIVE + HFP + HSYNC);
  localparam logic [10:0] VS_ON  = 11'(VACTIVE + VFP);
  localparam logic [10:0] VS_OFF = 11'(VACTIVE + VFP + VSYNC);

  logic [10:0] x_nxt;
  logic [10:0] y_nxt;
  logic        sof_nxt;
  logic        eof_nxt;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        blank_nxt;

  // Decode from the next position so every flag lands in the same cycle as x/y.
  always_comb begin
    x_nxt = x + 11'd1;
    y_nxt = y;
    if (x == X_LAST) begin
      x_nxt = 11'd0;
      y_nxt = (y == Y_LAST) ? 11'd0 : y + 11'd1;
    end
    sof_nxt   = (x_nxt == 11'd0) && (y_nxt == 11'd0);
    eof_nxt   = (x_nxt == X_ACT) && (y_nxt == Y_EOF);
    blank_nxt = (x_nxt >= X_ACT) || (y_nxt >= Y_ACT);
    hs_nxt    = ((x_nxt >= HS_ON) && (x_nxt < HS_OFF)) ? HS_POL : ~HS_POL;
    vs_nxt    = ((y_nxt >= VS_ON) && (y_nxt < VS_OFF)) ? VS_POL : ~VS_POL;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x         <= X_LAST;
      y         <= Y_LAST;
      hsync     <= ~HS_POL;
      vsync     <= ~VS_POL;
      blank     <= 1'b1;
      SOF       <= 1'b0;
      EOF       <= 1'b0;
      frame_cnt <= 8'd0;
    end else if (pix_ce) begin
      x     <= x_nxt;
      y     <= y_nxt;
      hsync <= hs_nxt;
      vsync <= vs_nxt;
      blank <= blank_nxt;
      SOF   <= sof_nxt;
      EOF   <= eof_nxt;
      if (sof_nxt) frame_cnt <= frame_cnt + 8'd1;
    end else begin
      // Markers are single-cycle: a stalled tick must not stretch them.
      SOF <= 1'b0;
      EOF <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for reset/line timing and a shrunken instance for frame-level checks.
module tb_vga_timing_gen;

  localparam int B_HT = 1040, B_VT = 666;
  localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VA = 6, S_VF = 2, S_VS = 2, S_VB = 2;
  localparam bit S_HPOL = 1'b0, S_VPOL = 1'b0;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
  localparam int S_FR = S_HT * S_VT;
  localparam int S_GAP = (S_HT - S_HA) + (S_VT - S_VA) * S_HT;

  logic clk = 1'b0;
  logic rst_n;
  logic b_ce, s_ce;
  logic [10:0] b_x, b_y, s_x, s_y;
  logic b_hs, b_vs, b_bl, b_sof, b_eof, s_hs, s_vs, s_bl, s_sof, s_eof;
  logic [7:0] b_fc, s_fc;

  int b_p, s_p, b_fcm, s_fcm;
  bit b_adv, s_adv;
  int n_chk = 0;
  int n_fail = 0;

  wire [34:0] b_obs = {b_x, b_y, b_hs, b_vs, b_bl, b_sof, b_eof, b_fc};
  wire [34:0] s_obs = {s_x, s_y, s_hs, s_vs, s_bl, s_sof, s_eof, s_fc};

  always #5 clk = ~clk;

  vga_timing_gen u_big (
    .clk(clk), .reset_n(rst_n), .pix_ce(b_ce), .x(b_x), .y(b_y), .hsync(b_hs), .vsync(b_vs),
    .blank(b_bl), .SOF(b_sof), .EOF(b_eof), .frame_cnt(b_fc)
  );

  vga_timing_gen #(
    .HACTIVE(S_HA), .HFP(S_HF), .HSYNC(S_HS), .HBP(S_HB),
    .VACTIVE(S_VA), .VFP(S_VF), .VSYNC(S_VS), .VBP(S_VB),
    .HS_POL(S_HPOL), .VS_POL(S_VPOL)
  ) u_small (
    .clk(clk), .reset_n(rst_n), .pix_ce(s_ce), .x(s_x), .y(s_y), .hsync(s_hs), .vsync(s_vs),
    .blank(s_bl), .SOF(s_sof), .EOF(s_eof), .frame_cnt(s_fc)
  );

  // Reference: raster position as a linear index p = y*HTOTAL + x; outputs follow from the timing rules.
  function automatic logic [34:0] exp_vec(input int p, input bit adv, input int fc, input bit sm);
    int ht, ha, hf, hs, va, vf, vs, xx, yy;
    bit hp, vp;
    logic hsy, vsy, bl, sof, eof;
    if (sm) begin
      ht = S_HT; ha = S_HA; hf = S_HF; hs = S_HS; va = S_VA; vf = S_VF; vs = S_VS; hp = S_HPOL; vp = S_VPOL;
    end else begin
      ht = B_HT; ha = 800; hf = 56; hs = 120; va = 600; vf = 37; vs = 6; hp = 1'b1; vp = 1'b1;
    end
    xx  = p % ht;
    yy  = p / ht;
    bl  = (xx >= ha) || (yy >= va);
    hsy = (xx >= ha + hf && xx < ha + hf + hs) ? hp : !hp;
    vsy = (yy >= va + vf && yy < va + vf + vs) ? vp : !vp;
    sof = adv && (p == 0);
    eof = adv && (p == (va - 1) * ht + ha);
    return {11'(xx), 11'(yy), hsy, vsy, bl, sof, eof, 8'(fc)};
  endfunction

  task automatic model_reset();
    b_p = B_HT * B_VT - 1; s_p = S_FR - 1;
    b_fcm = 0; s_fcm = 0; b_adv = 1'b0; s_adv = 1'b0;
  endtask

  task automatic step(input bit bce, input bit sce);
    b_ce = bce; s_ce = sce;
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      b_adv = b_ce; s_adv = s_ce;
      if (b_ce) begin
        b_p = (b_p + 1) % (B_HT * B_VT);
        if (b_p == 0) b_fcm = (b_fcm + 1) % 256;
      end
      if (s_ce) begin
        s_p = (s_p + 1) % S_FR;
        if (s_p == 0) s_fcm = (s_fcm + 1) % 256;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) step(1, 1);
    n_chk++; if (b_x !== 11'd1039 || b_y !== 11'd665) begin n_fail++; $display("FAIL reset_xy: got x=%0d y=%0d want 1039/665", b_x, b_y); end
    n_chk++; if ({b_bl, b_hs, b_vs, b_sof, b_eof} !== 5'b10000) begin n_fail++; $display("FAIL reset_flags: got bl/hs/vs/sof/eof=%b want 10000", {b_bl, b_hs, b_vs, b_sof, b_eof}); end
    n_chk++; if (b_fc !== 8'd0) begin n_fail++; $display("FAIL reset_fc: got %0d want 0", b_fc); end
    n_chk++; if (s_obs !== exp_vec(s_p, s_adv, s_fcm, 1)) begin n_fail++; $display("FAIL reset_small: got %h want %h", s_obs, exp_vec(s_p, s_adv, s_fcm, 1)); end
    rst_n = 1'b1;
    step(1, 1);
    n_chk++; if (b_sof !== 1'b1 || b_x !== 11'd0 || b_y !== 11'd0 || b_bl !== 1'b0 || b_fc !== 8'd1) begin
      n_fail++; $display("FAIL first_sof: got sof=%b x=%0d y=%0d bl=%b fc=%0d want 1,0,0,0,1", b_sof, b_x, b_y, b_bl, b_fc);
    end
  endtask

  task automatic test_horizontal();
    int hs_len, px, py, last_x0, i;
    logic phs, pbl;
    px = b_x; py = b_y; phs = b_hs; pbl = b_bl; hs_len = 0; last_x0 = 0;
    for (i = 1; i <= 2 * B_HT + 50; i++) begin
      step(1, 0);
      n_chk++; if (b_obs !== exp_vec(b_p, b_adv, b_fcm, 0)) begin n_fail++; $display("FAIL horiz_model cyc %0d: got %h want %h", i, b_obs, exp_vec(b_p, b_adv, b_fcm, 0)); end
      if (b_hs && !phs) begin
        n_chk++; if (b_x !== 11'd856) begin n_fail++; $display("FAIL hsync_rise: got x=%0d want 856", b_x); end
        hs_len = 0;
      end
      if (b_hs) hs_len++;
      if (!b_hs && phs) begin
        n_chk++; if (hs_len != 120) begin n_fail++; $display("FAIL hsync_width: got %0d want 120", hs_len); end
      end
      if (b_bl && !pbl) begin
        n_chk++; if (b_x !== 11'd800) begin n_fail++; $display("FAIL blank_rise: got x=%0d want 800", b_x); end
      end
      if (px == 1039) begin
        n_chk++; if (b_x !== 11'd0 || b_y !== 11'(py + 1)) begin n_fail++; $display("FAIL line_wrap: got x=%0d y=%0d want 0/%0d", b_x, b_y, py + 1); end
        n_chk++; if (i - last_x0 != 1040) begin n_fail++; $display("FAIL line_period: got %0d want 1040", i - last_x0); end
        last_x0 = i;
      end
      px = b_x; py = b_y; phs = b_hs; pbl = b_bl;
    end
  endtask

  task automatic test_frames();
    int last_eof, last_sof, vs_cnt;
    last_eof = -1; last_sof = -1; vs_cnt = 0;
    for (int c = 0; c < 3 * S_FR + 5; c++) begin
      step(0, 1);
      n_chk++; if (s_obs !== exp_vec(s_p, s_adv, s_fcm, 1)) begin n_fail++; $display("FAIL frame_model cyc %0d: got %h want %h", c, s_obs, exp_vec(s_p, s_adv, s_fcm, 1)); end
      if (s_vs == S_VPOL) vs_cnt++;
      if (s_eof) last_eof = c;
      if (s_sof) begin
        if (last_eof >= 0) begin
          n_chk++; if (c - last_eof != S_GAP) begin n_fail++; $display("FAIL eof_to_sof: got %0d want %0d", c - last_eof, S_GAP); end
        end
        if (last_sof >= 0) begin
          n_chk++; if (c - last_sof != S_FR) begin n_fail++; $display("FAIL sof_period: got %0d want %0d", c - last_sof, S_FR); end
          n_chk++; if (vs_cnt != S_VS * S_HT) begin n_fail++; $display("FAIL vsync_len: got %0d want %0d", vs_cnt, S_VS * S_HT); end
        end
        last_sof = c; vs_cnt = 0;
      end
    end
  endtask

  task automatic test_gating();
    int last_eof, last_sof;
    bit ce;
    last_eof = -1; last_sof = -1;
    for (int c = 0; c < 2 * S_FR * 2 + 4; c++) begin
      step(0, (c % 2) == 0);
      n_chk++; if (s_obs !== exp_vec(s_p, s_adv, s_fcm, 1)) begin n_fail++; $display("FAIL half_rate_model cyc %0d: got %h want %h", c, s_obs, exp_vec(s_p, s_adv, s_fcm, 1)); end
      if (s_eof) last_eof = c;
      if (s_sof) begin
        if (last_eof >= 0) begin
          n_chk++; if (c - last_eof != 2 * S_GAP) begin n_fail++; $display("FAIL half_eof_to_sof: got %0d want %0d", c - last_eof, 2 * S_GAP); end
        end
        if (last_sof >= 0) begin
          n_chk++; if (c - last_sof != 2 * S_FR) begin n_fail++; $display("FAIL half_sof_period: got %0d want %0d", c - last_sof, 2 * S_FR); end
        end
        last_sof = c;
      end
    end
    for (int c = 0; c < 3 * S_FR; c++) begin
      ce = 1'($urandom_range(0, 1));
      step(0, ce);
      n_chk++; if (s_obs !== exp_vec(s_p, s_adv, s_fcm, 1)) begin n_fail++; $display("FAIL rand_ce_model cyc %0d ce=%b: got %h want %h", c, ce, s_obs, exp_vec(s_p, s_adv, s_fcm, 1)); end
    end
  endtask

  task automatic test_reset_mid();
    int target, n;
    target = (S_VA / 2) * S_HT + S_HA / 2;
    n = 0;
    while (s_p != target && n < 2 * S_FR) begin step(0, 1); n++; end
    n_chk++; if (s_p != target) begin n_fail++; $display("FAIL mid_reach: got p=%0d want %0d", s_p, target); end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    n_chk++; if (s_obs !== exp_vec(s_p, s_adv, s_fcm, 1)) begin n_fail++; $display("FAIL mid_reset_async: got %h want %h", s_obs, exp_vec(s_p, s_adv, s_fcm, 1)); end
    n_chk++; if (b_obs !== exp_vec(b_p, b_adv, b_fcm, 0)) begin n_fail++; $display("FAIL mid_reset_big: got %h want %h", b_obs, exp_vec(b_p, b_adv, b_fcm, 0)); end
    repeat (2) begin
      step(1, 1);
      n_chk++; if (s_eof !== 1'b0 || s_sof !== 1'b0 || s_x !== 11'(S_HT - 1)) begin n_fail++; $display("FAIL mid_reset_hold: got eof=%b sof=%b x=%0d want 0,0,%0d", s_eof, s_sof, s_x, S_HT - 1); end
    end
    rst_n = 1'b1;
    step(0, 0);
    n_chk++; if (s_obs !== exp_vec(s_p, s_adv, s_fcm, 1)) begin n_fail++; $display("FAIL post_reset_idle: got %h want %h", s_obs, exp_vec(s_p, s_adv, s_fcm, 1)); end
    step(0, 1);
    n_chk++; if (s_sof !== 1'b1 || s_fc !== 8'd1 || s_x !== 11'd0 || s_y !== 11'd0) begin
      n_fail++; $display("FAIL post_reset_sof: got sof=%b fc=%0d x=%0d y=%0d want 1,1,0,0", s_sof, s_fc, s_x, s_y);
    end
  endtask

  task automatic test_wrap();
    int n_sof, c;
    n_sof = 1;
    c = 0;
    while (n_sof < 256 && c < 256 * S_FR + 10) begin
      step(0, 1);
      c++;
      n_chk++; if (s_obs !== exp_vec(s_p, s_adv, s_fcm, 1)) begin n_fail++; $display("FAIL wrap_model cyc %0d: got %h want %h", c, s_obs, exp_vec(s_p, s_adv, s_fcm, 1)); end
      n_chk++; if (s_x >= 11'(S_HT) || s_y >= 11'(S_VT)) begin n_fail++; $display("FAIL wrap_bounds: got x=%0d y=%0d want <%0d/<%0d", s_x, s_y, S_HT, S_VT); end
      if (s_sof) begin
        n_sof++;
        if (n_sof == 256) begin
          n_chk++; if (s_fc !== 8'd0) begin n_fail++; $display("FAIL fc_wrap: got %0d want 0", s_fc); end
        end
      end
    end
    n_chk++; if (n_sof != 256) begin n_fail++; $display("FAIL wrap_timeout: got %0d SOFs want 256", n_sof); end
  endtask

  initial begin
    b_ce = 1'b0; s_ce = 1'b0;
    test_reset();
    test_horizontal();
    test_frames();
    test_gating();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Generates 800x600@72 Hz VGA raster timing from the 50 MHz system clock. Outputs the current raster position (x, y), sync and blanking signals, and single-cycle SOF/EOF frame markers. The player position controller uses SOF/EOF as its update window; the pixel renderers consume x/y. Sits at the head of the video pipeline; every display stage is downstream of it.

Parameters:
HACTIVE, 800, visible pixels per line
HFP, 56, horizontal front porch (pixels)
HSYNC, 120, horizontal sync width (pixels)
HBP, 64, horizontal back porch (pixels)
VACTIVE, 600, visible lines per frame
VFP, 37, vertical front porch (lines)
VSYNC, 6, vertical sync width (lines)
VBP, 23, vertical back porch (lines)
HS_POL, 1, hsync active level
VS_POL, 1, vsync active level

Ports:
clk  in  1  system clock, 50 MHz
reset_n  in  1  asynchronous active-low reset
pix_ce  in  1  pixel-advance enable (tie 1 for a 50 MHz pixel rate)
x  out  11  current horizontal counter, 0..HTOTAL-1
y  out  11  current vertical counter, 0..VTOTAL-1
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
blank  out  1  1 outside the active area
SOF  out  1  one-clk pulse at the start of the active frame
EOF  out  1  one-clk pulse right after the last active pixel
frame_cnt  out  8  frame counter, increments with SOF

Behaviour:
- Interface: reset reset_n, asynchronous, active-low; clock clk.
- HTOTAL = HACTIVE+HFP+HSYNC+HBP (1040). VTOTAL = VACTIVE+VFP+VSYNC+VBP (666).
- All outputs are registered and mutually aligned. hsync, vsync, blank, SOF and EOF always describe the position currently on x/y.
- Reset (async): x=HTOTAL-1, y=VTOTAL-1, blank=1, hsync=!HS_POL, vsync=!VS_POL, SOF=0, EOF=0, frame_cnt=0.
- Advance happens only on a clk edge with pix_ce=1:
  - x increments.
  - At x=HTOTAL-1, x wraps to 0 and y increments.
  - At y=VTOTAL-1 with x=HTOTAL-1, both wrap to 0.
- pix_ce=0 holds x, y, hsync, vsync, blank and frame_cnt unchanged. SOF and EOF are forced to 0.
- blank = (x >= HACTIVE) or (y >= VACTIVE).
- hsync active for HACTIVE+HFP <= x < HACTIVE+HFP+HSYNC (x = 856..975).
- vsync active for VACTIVE+VFP <= y < VACTIVE+VFP+VSYNC (y = 637..642). vsync is a function of y only.
- SOF = 1 for exactly one clk on the advance that lands on (0,0). frame_cnt increments on the same edge.
- EOF = 1 for exactly one clk on the advance that lands on (HACTIVE, VACTIVE-1) = (800,599).
- SOF and EOF never coincide. Between EOF and SOF the downstream window is 240 + 66*1040 = 68880 pixel ticks.
- First advance after reset lands on (0,0): the first SOF is on the first pix_ce, and frame_cnt becomes 1.
- frame_cnt wraps 255 -> 0 silently.
- Reset asserted mid-frame returns everything to reset values immediately, with no pulse emitted. On release, the first advance produces SOF.
- Free-running: no stall or back-pressure inputs.

Test Plan:
- Reset check: assert reset_n=0 for 3 clks with pix_ce=1 -> x=1039, y=665, blank=1, hsync=0, vsync=0, SOF=0, EOF=0, frame_cnt=0. Release -> next clk SOF=1, x=0, y=0, blank=0, frame_cnt=1.
- Horizontal timing (pix_ce=1):
  - hsync rises at x=856 and stays high exactly 120 clks.
  - blank rises at x=800.
  - Line period is 1040 clks; y increments as x goes 1039 -> 0.
- Frame markers:
  - EOF pulses once, 1 clk wide, at (800,599).
  - vsync high for lines 637..642 (6*1040 clks).
  - Next SOF arrives 68880 clks after EOF.
  - SOF-to-SOF period is 692640 clks.
- pix_ce gating: drive pix_ce=1 every other clk -> all periods double in clk count. With pix_ce=0 on the landing clk, SOF/EOF are delayed to the next enabled edge and stay 1 clk wide. Outputs hold while pix_ce=0.
- Reset mid-frame: assert reset_n at (400,300) -> immediate return to reset values, no EOF emitted. After release, SOF appears on the first pix_ce.
- Wrap: run 256 frames -> frame_cnt returns to 0 on the 256th SOF, and x/y never exceed 1039/665.
